// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Responder end of a core data-memory port. A load or store is accepted over a
// valid/ready handshake while idle. After WAIT_STATES extra cycles, a one-cycle
// response is returned. Storage is a word-organised 32-bit RAM with
// 2**ADDR_WIDTH entries. Byte address bits [1:0] are ignored.
//
// Optional feature: define DATA_MEMORY_RANGE_CHECK_EN to flag requests whose
// address has any bit above ADDR_WIDTH+1 set. Such a request answers with
// response_error=1 and response_data=0, and a flagged store is dropped. Without
// the macro, upper address bits are ignored, so addresses alias modulo the RAM
// size, and response_error stays 0.
//
// Ports:
//   clock               rising-edge clock
//   reset               asynchronous active-low reset
//   request_valid       request present
//   request_ready       high only while idle
//   request_write       1 = store, 0 = load
//   request_address     byte address
//   request_write_data  lane-aligned store data
//   request_write_mask  byte-lane enables for stores
//   response_valid      one-cycle completion pulse
//   response_data       load data (0 for stores / errors), held until next response
//   response_error      out-of-range flag, held until next response
module data_memory_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        request_valid,
   output logic        request_ready,
   input  logic        request_write,
   input  logic [31:0] request_address,
   input  logic [31:0] request_write_data,
   input  logic [3:0]  request_write_mask,
   output logic        response_valid,
   output logic [31:0] response_data,
   output logic        response_error
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            mask_q, mask_d;
   logic                  err_q, err_d;
   logic [31:0]           rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [31:0]           mem [Depth];

   logic [ADDR_WIDTH-1:0] req_idx;
   logic                  req_err;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic                  rd_wr;
   logic                  rd_err;

   assign req_idx = request_address[ADDR_WIDTH+1:2];

`ifdef DATA_MEMORY_RANGE_CHECK_EN
   logic unused_addr;
   assign unused_addr = ^request_address[1:0];
   assign req_err     = |request_address[31:ADDR_WIDTH+2];
`else
   logic unused_addr;
   assign unused_addr = ^{request_address[31:ADDR_WIDTH+2], request_address[1:0]};
   assign req_err     = 1'b0;
`endif

   // Next-state and request latching
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (request_valid) begin
               wr_d    = request_write;
               idx_d   = req_idx;
               wdata_d = request_write_data;
               mask_d  = request_write_mask;
               err_d   = req_err;
               cnt_d   = 4'(WAIT_STATES);
               state_d = (WAIT_STATES == 0) ? StRespond : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            // <= guards against a zero count ever stalling the FSM.
            if (cnt_q <= 4'd1) begin
               state_d = StRespond;
            end
         end
         StRespond: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // With zero wait states, RESPOND follows IDLE directly. In that case the
   // response is built from the live request rather than the latched copy.
   always_comb begin
      rd_idx = idx_q;
      rd_wr  = wr_q;
      rd_err = err_q;
      if (state_q == StIdle) begin
         rd_idx = req_idx;
         rd_wr  = request_write;
         rd_err = req_err;
      end
   end

   // Response registers are loaded only on the edge entering RESPOND. They
   // hold their values until the next RESPOND.
   always_comb begin
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      if (state_d == StRespond && state_q != StRespond) begin
         rsp_data_d = (rd_wr || rd_err) ? 32'h0 : mem[rd_idx];
         rsp_err_d  = rd_err;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         wr_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= 32'h0;
         mask_q     <= 4'h0;
         err_q      <= 1'b0;
         rsp_data_q <= 32'h0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
         err_q      <= err_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // The RAM is not reset. Reset forces the state to IDLE asynchronously, so an
   // in-flight store never reaches the write below.
   always_ff @(posedge clock) begin
      if (state_q == StRespond && wr_q && !err_q) begin
         for (int b = 0; b < 4; b++) begin
            if (mask_q[b]) begin
               mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign request_ready  = (state_q == StIdle);
   assign response_valid = (state_q == StRespond);
   assign response_data  = rsp_data_q;
   assign response_error = rsp_err_q;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the core's data-memory port: accepts load/store requests (address, write data, byte mask) over a valid/ready handshake and returns a registered response after a programmable number of wait states.
- Holds a word-organised RAM. Lets multicycle/pipelined cores and benches exercise stall paths with a realistic data memory instead of a combinational array.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 1, extra cycles between accept and response (0..15).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- request_valid  in  1  requester presents a request.
- request_ready  out  1  responder can accept; transfer when valid&&ready on a rising edge.
- request_write  in  1  1 = store, 0 = load.
- request_address  in  32  byte address; bits [1:0] ignored (word access).
- request_write_data  in  32  store data, lane-aligned.
- request_write_mask  in  4  byte-lane enables for stores; bit i covers data[8i+7:8i].
- response_valid  out  1  one-cycle pulse: request complete.
- response_data  out  32  load data; 0 for stores.
- response_error  out  1  out-of-range flag; see Optional Feature.

Behaviour:
- States: IDLE, WAIT, RESPOND. Encoding is free.
- request_ready = 1 only in IDLE, decoded from state. request_valid is ignored outside IDLE; the requester holds the request until accepted.
- Accept in IDLE: latch write flag, word index = address[ADDR_WIDTH+1:2], write data, mask. Load the wait counter with WAIT_STATES.
  - WAIT_STATES=0 -> next state RESPOND.
  - Otherwise -> WAIT.
- WAIT: decrement the counter each cycle; go to RESPOND in the cycle after the counter reaches 1.
- RESPOND: response_valid=1 for exactly this cycle, then IDLE.
  - Latency: response_valid is high in cycle accept+WAIT_STATES+1.
  - Throughput: one request per WAIT_STATES+2 cycles.
- Load: response_data = RAM word at the latched index, registered, and valid in the RESPOND cycle.
- Store: masked lanes are written on the rising edge that ends RESPOND; response_data=0.
  - Unmasked lanes are unchanged.
  - mask=4'b0000 completes normally and modifies nothing.
- response_data and response_error hold their values until the next RESPOND cycle. They are only meaningful while response_valid=1.
- Address wrap: without range checking, upper address bits above ADDR_WIDTH+1 are ignored, so the address aliases modulo RAM size.
- No response backpressure: the requester must sample in the RESPOND cycle.
- Reset (reset=0, any time, asynchronous):
  - state=IDLE, counter=0, request_ready=1, response_valid=0, response_data=0, response_error=0.
  - An in-flight store is discarded with no RAM write.
  - RAM contents are not cleared.
- Load following a completed store to the same word returns the merged new data.

Optional Feature:
- Macro: DATA_MEMORY_RANGE_CHECK_EN.
- Defined:
  - An accepted request with any address bit above ADDR_WIDTH+1 set is flagged at accept.
  - In its RESPOND cycle: response_error=1, response_data=0, and the store is suppressed.
  - Latency is unchanged.
- Undefined: response_error is tied to 0 and addresses alias as described above.

Test Plan:
- Reset then idle, WAIT_STATES=1 -> request_ready=1, response_valid=0, response_data=0 for 10 cycles. Assert reset mid-WAIT of a store to 0x40 -> ready=1 next edge, later load of 0x40 returns old value.
- Store 0x40 data 0xDEADBEEF mask 4'b1111, then load 0x40 -> response_valid exactly 2 cycles after each accept (WAIT_STATES=1); load data 0xDEADBEEF; store response_data=0.
- Store 0x40 data 0x00001122 mask 4'b0011 over 0xDEADBEEF -> load returns 0xDEAD1122. Mask 4'b0000 store of 0xFFFFFFFF -> unchanged.
- WAIT_STATES=0: back-to-back valid held high for 3 loads -> accepts every 2nd cycle, response_valid pulses one cycle each, ready=0 in RESPOND cycles.
- ADDR_WIDTH=10, store 0x1000_0004 data 0x12345678:
  - Without macro: load 0x4 returns 0x12345678, response_error=0.
  - With DATA_MEMORY_RANGE_CHECK_EN: response_error=1, load 0x4 unchanged.
- Request held while busy (WAIT_STATES=3) -> accepted only on return to IDLE, and exactly one response per accepted request.
